// File: rtl/bsg_cache_dma_rr_arbiter_pkg.sv
// rtl/bsg_cache_dma_rr_arbiter_pkg.sv - shared state type and width helper for the vcache DMA arbiter
package bsg_cache_dma_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_EVICT = 2'd2
  } dma_state_e;

  // Width of an index into n items; never below one bit.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_cache_dma_rr_arbiter_if.sv
// rtl/bsg_cache_dma_rr_arbiter_if.sv - cache-side and adapter-side DMA signals of the arbiter
interface bsg_cache_dma_rr_arbiter_if #(
  parameter int num_cache_p      = 2,
  parameter int addr_width_p     = 32,
  parameter int dma_data_width_p = 32
);
  import bsg_cache_dma_rr_arbiter_pkg::*;

  localparam int pkt_width_lp = 1 + addr_width_p;
  localparam int id_width_lp  = safe_clog2(num_cache_p);

  logic [num_cache_p-1:0][pkt_width_lp-1:0]     cache_dma_pkt_i;
  logic [num_cache_p-1:0]                       cache_dma_pkt_v_i;
  logic [num_cache_p-1:0]                       cache_dma_pkt_yumi_o;
  logic [dma_data_width_p-1:0]                  cache_dma_data_o;
  logic [num_cache_p-1:0]                       cache_dma_data_v_o;
  logic [num_cache_p-1:0]                       cache_dma_data_ready_i;
  logic [num_cache_p-1:0][dma_data_width_p-1:0] cache_dma_data_i;
  logic [num_cache_p-1:0]                       cache_dma_data_v_i;
  logic [num_cache_p-1:0]                       cache_dma_data_yumi_o;

  logic [pkt_width_lp-1:0]     mem_dma_pkt_o;
  logic                        mem_dma_pkt_v_o;
  logic                        mem_dma_pkt_yumi_i;
  logic [dma_data_width_p-1:0] mem_dma_data_i;
  logic                        mem_dma_data_v_i;
  logic                        mem_dma_data_ready_o;
  logic [dma_data_width_p-1:0] mem_dma_data_o;
  logic                        mem_dma_data_v_o;
  logic                        mem_dma_data_yumi_i;
  logic [id_width_lp-1:0]      mem_cache_id_o;

  modport slave (
    input  cache_dma_pkt_i, cache_dma_pkt_v_i, cache_dma_data_ready_i,
           cache_dma_data_i, cache_dma_data_v_i,
           mem_dma_pkt_yumi_i, mem_dma_data_i, mem_dma_data_v_i, mem_dma_data_yumi_i,
    output cache_dma_pkt_yumi_o, cache_dma_data_o, cache_dma_data_v_o, cache_dma_data_yumi_o,
           mem_dma_pkt_o, mem_dma_pkt_v_o, mem_dma_data_ready_o, mem_dma_data_o,
           mem_dma_data_v_o, mem_cache_id_o
  );

  modport master (
    output cache_dma_pkt_i, cache_dma_pkt_v_i, cache_dma_data_ready_i,
           cache_dma_data_i, cache_dma_data_v_i,
           mem_dma_pkt_yumi_i, mem_dma_data_i, mem_dma_data_v_i, mem_dma_data_yumi_i,
    input  cache_dma_pkt_yumi_o, cache_dma_data_o, cache_dma_data_v_o, cache_dma_data_yumi_o,
           mem_dma_pkt_o, mem_dma_pkt_v_o, mem_dma_data_ready_o, mem_dma_data_o,
           mem_dma_data_v_o, mem_cache_id_o
  );

endinterface

// File: rtl/bsg_cache_dma_rr_arbiter_arb.sv
// rtl/bsg_cache_dma_rr_arbiter_arb.sv - round-robin winner select with a pointer that moves past each grant
module bsg_cache_dma_rr_arbiter_arb
  import bsg_cache_dma_rr_arbiter_pkg::*;
#(
  parameter int width_p = 2,
  localparam int id_width_lp = safe_clog2(width_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     reqs_i,
  input  logic                   yumi_i,
  output logic                   v_o,
  output logic [id_width_lp-1:0] id_o
);

  logic [id_width_lp-1:0] ptr_q, ptr_d;
  logic [id_width_lp-1:0] cand;

  // Scan from the far end so the requester closest to the pointer is written last and wins.
  always_comb begin
    v_o  = 1'b0;
    id_o = '0;
    cand = '0;
    for (int k = width_p - 1; k >= 0; k--) begin
      cand = id_width_lp'((int'(ptr_q) + k) % width_p);
      if (reqs_i[cand]) begin
        v_o  = 1'b1;
        id_o = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (yumi_i && v_o)
      ptr_d = (int'(id_o) == width_p - 1) ? '0 : id_o + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bsg_cache_dma_rr_arbiter.sv
// rtl/bsg_cache_dma_rr_arbiter.sv - shares one vcache DMA port among several caches, one block transfer at a time
module bsg_cache_dma_rr_arbiter
  import bsg_cache_dma_rr_arbiter_pkg::*;
#(
  parameter int num_cache_p           = 2,
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int dma_data_width_p      = 32
) (
  input logic                          clk_i,
  input logic                          reset_i,
  bsg_cache_dma_rr_arbiter_if.slave    bus_if
);

  localparam int pkt_width_lp = 1 + addr_width_p;
  localparam int beats_lp     = data_width_p * block_size_in_words_p / dma_data_width_p;
  localparam int id_width_lp  = safe_clog2(num_cache_p);
  localparam int cnt_width_lp = safe_clog2(beats_lp);
  localparam logic [cnt_width_lp-1:0] last_beat_lp = cnt_width_lp'(beats_lp - 1);

  dma_state_e              state_q, state_d;
  logic [id_width_lp-1:0]  id_q, id_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;

  logic [num_cache_p-1:0]  arb_reqs;
  logic                    arb_v;
  logic [id_width_lp-1:0]  arb_id;
  logic                    grant;
  logic                    beat;

  assign arb_reqs = (state_q == ST_IDLE) ? bus_if.cache_dma_pkt_v_i : '0;
  assign grant    = (state_q == ST_IDLE) && arb_v && bus_if.mem_dma_pkt_yumi_i && !reset_i;

  bsg_cache_dma_rr_arbiter_arb #(.width_p(num_cache_p)) arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .reqs_i  (arb_reqs),
    .yumi_i  (grant),
    .v_o     (arb_v),
    .id_o    (arb_id)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    beat    = 1'b0;
    bus_if.cache_dma_pkt_yumi_o  = '0;
    bus_if.cache_dma_data_v_o    = '0;
    bus_if.cache_dma_data_yumi_o = '0;
    bus_if.mem_dma_pkt_v_o       = 1'b0;
    bus_if.mem_dma_data_ready_o  = 1'b0;
    bus_if.mem_dma_data_v_o      = 1'b0;
    bus_if.mem_dma_pkt_o         = bus_if.cache_dma_pkt_i[arb_id];
    bus_if.mem_cache_id_o        = id_q;
    bus_if.cache_dma_data_o      = bus_if.mem_dma_data_i;
    bus_if.mem_dma_data_o        = bus_if.cache_dma_data_i[id_q];

    // Every valid/ready/yumi stays low for as long as reset is held.
    if (!reset_i) begin
      case (state_q)
        ST_IDLE: begin
          bus_if.mem_dma_pkt_v_o = arb_v;
          bus_if.mem_cache_id_o  = arb_id;
          if (grant) begin
            bus_if.cache_dma_pkt_yumi_o[arb_id] = 1'b1;
            id_d    = arb_id;
            state_d = bus_if.cache_dma_pkt_i[arb_id][pkt_width_lp-1] ? ST_EVICT : ST_FILL;
          end
        end
        ST_FILL: begin
          bus_if.cache_dma_data_v_o[id_q] = bus_if.mem_dma_data_v_i;
          bus_if.mem_dma_data_ready_o     = bus_if.cache_dma_data_ready_i[id_q];
          beat = bus_if.mem_dma_data_v_i && bus_if.cache_dma_data_ready_i[id_q];
        end
        ST_EVICT: begin
          bus_if.cache_dma_data_yumi_o[id_q] = bus_if.mem_dma_data_yumi_i;
          bus_if.mem_dma_data_v_o            = bus_if.cache_dma_data_v_i[id_q];
          beat = bus_if.mem_dma_data_yumi_i;
        end
        default: state_d = ST_IDLE;
      endcase

      if (beat) begin
        if (cnt_q == last_beat_lp) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  // Adapter protocol: fill beats only while filling, evict yumi only on an offered beat.
  assert property (@(posedge clk_i) disable iff (reset_i)
    bus_if.mem_dma_data_v_i |-> (state_q == ST_FILL));
  assert property (@(posedge clk_i) disable iff (reset_i)
    bus_if.mem_dma_data_yumi_i |-> bus_if.mem_dma_data_v_o);

endmodule

// File: tb/tb_bsg_cache_dma_rr_arbiter.sv
// tb/tb_bsg_cache_dma_rr_arbiter.sv - randomized scenario bench with a transaction-level model of the arbiter
module tb_bsg_cache_dma_rr_arbiter;

  localparam int N     = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = 8;
  localparam int DDW   = 32;
  localparam int BEATS = DW * BW / DDW;
  localparam int IDW   = (N <= 1) ? 1 : $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bsg_cache_dma_rr_arbiter_if #(.num_cache_p(N), .addr_width_p(AW), .dma_data_width_p(DDW)) bus ();

  bsg_cache_dma_rr_arbiter #(
    .num_cache_p(N), .addr_width_p(AW), .data_width_p(DW),
    .block_size_in_words_p(BW), .dma_data_width_p(DDW)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus_if  (bus)
  );

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  int stray  = 0;
  logic [DDW-1:0] exp_q[$];
  logic [DDW-1:0] got_q[$];
  logic [AW:0]    pkt_m[N];

  // Model: first requester at or after the pointer, wrapping around.
  function automatic int rr_pick(input int vmask, input int ptr);
    for (int k = 0; k < N; k++)
      if (((vmask >> ((ptr + k) % N)) & 1) == 1) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int bad_beats();
    int bad;
    bad = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  function automatic logic [N-1:0] onehot(input int c);
    logic [N-1:0] o;
    o = '0;
    o[IDW'(c)] = 1'b1;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.cache_dma_pkt_i        = '0;
    bus.cache_dma_pkt_v_i      = '0;
    bus.cache_dma_data_ready_i = '0;
    bus.cache_dma_data_i       = '0;
    bus.cache_dma_data_v_i     = '0;
    bus.mem_dma_pkt_yumi_i     = 1'b0;
    bus.mem_dma_data_i         = '0;
    bus.mem_dma_data_v_i       = 1'b0;
    bus.mem_dma_data_yumi_i    = 1'b0;
  endtask

  task automatic new_scoreboard();
    exp_q.delete();
    got_q.delete();
    stray = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst   = 1'b0;
    ptr_m = 0;
  endtask

  task automatic set_pkt(input int c, input bit wr, input logic [AW-1:0] addr);
    pkt_m[c] = {wr, addr};
    bus.cache_dma_pkt_i[IDW'(c)] = pkt_m[c];
  endtask

  // Lone requester c granted in one cycle; model pointer moves past it.
  task automatic grant(input int c, input bit wr, input logic [AW-1:0] addr);
    set_pkt(c, wr, addr);
    bus.cache_dma_pkt_v_i  = onehot(c);
    bus.mem_dma_pkt_yumi_i = 1'b1;
    tick();
    bus.mem_dma_pkt_yumi_i = 1'b0;
    bus.cache_dma_pkt_v_i  = '0;
    ptr_m = (c + 1) % N;
  endtask

  // Moves nbeats of a block for owner c; records what reaches the far side and any off-protocol cycle.
  task automatic xfer(input int c, input bit wr, input bit gap, input int stall_at, input int nbeats);
    int beats = 0, stalls = 0, cyc = 0;
    bit take;
    logic [DDW-1:0] d;
    logic [IDW-1:0] ci;
    ci = IDW'(c);
    d  = $urandom;
    while (beats < nbeats && cyc < 200) begin
      take = 1'b0;
      if (wr) begin
        bus.cache_dma_data_i[ci]   = d;
        bus.cache_dma_data_v_i[ci] = 1'b1;
        bus.mem_dma_data_yumi_i    = gap ? cyc[0] : 1'b1;
        take = bus.mem_dma_data_yumi_i;
      end else begin
        bus.mem_dma_data_i   = d;
        bus.mem_dma_data_v_i = 1'b1;
        if (beats == stall_at && stalls < 3) begin
          bus.cache_dma_data_ready_i = '0;
          stalls++;
        end else begin
          bus.cache_dma_data_ready_i = onehot(c);
          take = 1'b1;
        end
      end
      #1;
      if (bus.mem_cache_id_o !== ci || bus.mem_dma_pkt_v_o !== 1'b0 || bus.cache_dma_pkt_yumi_o !== '0) stray++;
      if (wr) begin
        if (bus.cache_dma_data_yumi_o !== (take ? onehot(c) : '0) || bus.mem_dma_data_v_o !== 1'b1) stray++;
        if (take) got_q.push_back(bus.mem_dma_data_o);
      end else begin
        if (bus.cache_dma_data_v_o !== onehot(c) || bus.mem_dma_data_ready_o !== take) stray++;
        if (take) got_q.push_back(bus.cache_dma_data_o);
      end
      if (take) begin
        exp_q.push_back(d);
        beats++;
        d = $urandom;
      end
      cyc++;
      tick();
    end
    if (cyc >= 200) stray++;
    bus.mem_dma_data_v_i       = 1'b0;
    bus.cache_dma_data_v_i     = '0;
    bus.cache_dma_data_ready_i = '0;
    bus.mem_dma_data_yumi_i    = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus.cache_dma_pkt_v_i  = '1;
    bus.mem_dma_pkt_yumi_i = 1'b1;
    #1;
    checks++;
    if (bus.mem_dma_pkt_v_o !== 1'b0) begin errors++; $display("FAIL reset_pkt_v: got %0b want 0", bus.mem_dma_pkt_v_o); end
    checks++;
    if (bus.cache_dma_pkt_yumi_o !== '0) begin errors++; $display("FAIL reset_pkt_yumi: got %b want 0", bus.cache_dma_pkt_yumi_o); end
    checks++;
    if ({bus.cache_dma_data_v_o, bus.cache_dma_data_yumi_o, bus.mem_dma_data_ready_o, bus.mem_dma_data_v_o} !== '0) begin
      errors++;
      $display("FAIL reset_data_ctl: got %b want 0",
               {bus.cache_dma_data_v_o, bus.cache_dma_data_yumi_o, bus.mem_dma_data_ready_o, bus.mem_dma_data_v_o});
    end
    bus.mem_dma_pkt_yumi_i = 1'b0;
    tick();
    rst   = 1'b0;
    ptr_m = 0;
    #1;
    checks++;
    if (bus.mem_dma_pkt_v_o !== 1'b1 || bus.mem_cache_id_o !== IDW'(rr_pick(3, ptr_m))) begin
      errors++;
      $display("FAIL reset_first_pick: got v=%0b id=%0d want v=1 id=%0d", bus.mem_dma_pkt_v_o, bus.mem_cache_id_o, rr_pick(3, ptr_m));
    end
    bus.cache_dma_pkt_v_i = '0;
  endtask

  task automatic test_fill();
    new_scoreboard();
    set_pkt(0, 1'b0, 32'h100);
    bus.cache_dma_pkt_v_i = onehot(0);
    #1;
    checks++;
    if (bus.mem_dma_pkt_v_o !== 1'b1 || bus.mem_dma_pkt_o !== pkt_m[0] || bus.cache_dma_pkt_yumi_o !== '0) begin
      errors++;
      $display("FAIL fill_pkt: got v=%0b pkt=%h yumi=%b want v=1 pkt=%h yumi=0",
               bus.mem_dma_pkt_v_o, bus.mem_dma_pkt_o, bus.cache_dma_pkt_yumi_o, pkt_m[0]);
    end
    bus.mem_dma_pkt_yumi_i = 1'b1;
    #1;
    checks++;
    if (bus.cache_dma_pkt_yumi_o !== onehot(0)) begin
      errors++; $display("FAIL fill_pkt_yumi: got %b want %b", bus.cache_dma_pkt_yumi_o, onehot(0));
    end
    tick();
    bus.mem_dma_pkt_yumi_i = 1'b0;
    bus.cache_dma_pkt_v_i  = '0;
    ptr_m = 1 % N;
    xfer(0, 1'b0, 1'b0, -1, BEATS);
    checks++;
    if (bad_beats() != 0 || stray != 0) begin
      errors++; $display("FAIL fill_beats: got %0d bad beats %0d stray cycles want 0 0", bad_beats(), stray);
    end
    bus.cache_dma_pkt_v_i = onehot(1);
    #1;
    checks++;
    if (bus.mem_dma_pkt_v_o !== 1'b1 || bus.mem_cache_id_o !== IDW'(rr_pick(2, ptr_m))) begin
      errors++; $display("FAIL fill_idle_after: got v=%0b id=%0d want v=1 id=%0d", bus.mem_dma_pkt_v_o, bus.mem_cache_id_o, rr_pick(2, ptr_m));
    end
    bus.cache_dma_pkt_v_i = '0;
  endtask

  task automatic test_rr_alternate();
    int w;
    do_reset();
    bus.cache_dma_pkt_v_i = '1;
    for (int g = 0; g < 4; g++) begin
      new_scoreboard();
      for (int c = 0; c < N; c++) set_pkt(c, $urandom_range(0, 1) == 1, AW'($urandom));
      w = rr_pick((1 << N) - 1, ptr_m);
      #1;
      checks++;
      if (bus.mem_cache_id_o !== IDW'(w) || bus.mem_dma_pkt_o !== pkt_m[w] || bus.mem_dma_pkt_v_o !== 1'b1) begin
        errors++;
        $display("FAIL rr_pick_%0d: got id=%0d pkt=%h want id=%0d pkt=%h", g, bus.mem_cache_id_o, bus.mem_dma_pkt_o, w, pkt_m[w]);
      end
      bus.mem_dma_pkt_yumi_i = 1'b1;
      #1;
      checks++;
      if (bus.cache_dma_pkt_yumi_o !== onehot(w)) begin
        errors++; $display("FAIL rr_yumi_%0d: got %b want %b", g, bus.cache_dma_pkt_yumi_o, onehot(w));
      end
      tick();
      bus.mem_dma_pkt_yumi_i = 1'b0;
      ptr_m = (w + 1) % N;
      xfer(w, pkt_m[w][AW], 1'b0, -1, BEATS);
      checks++;
      if (bad_beats() != 0 || stray != 0) begin
        errors++; $display("FAIL rr_xfer_%0d: got %0d bad beats %0d stray cycles want 0 0", g, bad_beats(), stray);
      end
    end
    bus.cache_dma_pkt_v_i = '0;
  endtask

  task automatic test_evict();
    new_scoreboard();
    set_pkt(1, 1'b1, 32'h200);
    bus.cache_dma_pkt_v_i  = onehot(1);
    bus.mem_dma_pkt_yumi_i = 1'b1;
    #1;
    checks++;
    if (bus.mem_dma_pkt_o !== pkt_m[1] || bus.cache_dma_pkt_yumi_o !== onehot(1) || bus.mem_cache_id_o !== IDW'(1)) begin
      errors++;
      $display("FAIL evict_grant: got pkt=%h yumi=%b id=%0d want pkt=%h yumi=%b id=1",
               bus.mem_dma_pkt_o, bus.cache_dma_pkt_yumi_o, bus.mem_cache_id_o, pkt_m[1], onehot(1));
    end
    tick();
    bus.mem_dma_pkt_yumi_i = 1'b0;
    bus.cache_dma_pkt_v_i  = '0;
    ptr_m = 2 % N;
    xfer(1, 1'b1, 1'b1, -1, BEATS);
    checks++;
    if (bad_beats() != 0 || stray != 0 || got_q.size() != BEATS) begin
      errors++; $display("FAIL evict_beats: got %0d beats %0d bad %0d stray want %0d beats 0 0", got_q.size(), bad_beats(), stray, BEATS);
    end
  endtask

  task automatic test_fill_stall();
    new_scoreboard();
    grant(0, 1'b0, AW'($urandom));
    xfer(0, 1'b0, 1'b0, 4, BEATS);
    checks++;
    if (bad_beats() != 0 || stray != 0) begin
      errors++; $display("FAIL stall_beats: got %0d bad beats %0d stray cycles want 0 0", bad_beats(), stray);
    end
    bus.cache_dma_pkt_v_i = onehot(0);
    #1;
    checks++;
    if (bus.mem_dma_pkt_v_o !== 1'b1) begin
      errors++; $display("FAIL stall_idle_after: got pkt_v=%0b want 1", bus.mem_dma_pkt_v_o);
    end
    bus.cache_dma_pkt_v_i = '0;
  endtask

  task automatic test_reset_mid_evict();
    new_scoreboard();
    grant(1, 1'b1, AW'($urandom));
    xfer(1, 1'b1, 1'b0, -1, 3);
    set_pkt(0, 1'b0, AW'($urandom));
    set_pkt(1, 1'b1, AW'($urandom));
    bus.cache_dma_data_v_i[IDW'(1)] = 1'b1;
    bus.mem_dma_data_yumi_i         = 1'b1;
    bus.cache_dma_pkt_v_i           = '1;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_dma_data_v_o !== 1'b0 || bus.cache_dma_data_yumi_o !== '0 || bus.mem_dma_pkt_v_o !== 1'b0 || bus.mem_cache_id_o !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got data_v=%0b yumi=%b pkt_v=%0b id=%0d want 0 0 0 0",
               bus.mem_dma_data_v_o, bus.cache_dma_data_yumi_o, bus.mem_dma_pkt_v_o, bus.mem_cache_id_o);
    end
    bus.cache_dma_data_v_i  = '0;
    bus.mem_dma_data_yumi_i = 1'b0;
    tick();
    rst   = 1'b0;
    ptr_m = 0;
    new_scoreboard();
    bus.mem_dma_pkt_yumi_i = 1'b1;
    #1;
    checks++;
    if (bus.cache_dma_pkt_yumi_o !== onehot(rr_pick(3, ptr_m)) || bus.mem_dma_pkt_o !== pkt_m[rr_pick(3, ptr_m)]) begin
      errors++;
      $display("FAIL midreset_regrant: got yumi=%b pkt=%h want yumi=%b pkt=%h",
               bus.cache_dma_pkt_yumi_o, bus.mem_dma_pkt_o, onehot(rr_pick(3, ptr_m)), pkt_m[rr_pick(3, ptr_m)]);
    end
    tick();
    bus.mem_dma_pkt_yumi_i = 1'b0;
    bus.cache_dma_pkt_v_i  = '0;
    ptr_m = 1 % N;
    xfer(0, 1'b0, 1'b0, -1, BEATS);
    checks++;
    if (bad_beats() != 0 || stray != 0) begin
      errors++; $display("FAIL midreset_fill: got %0d bad beats %0d stray cycles want 0 0", bad_beats(), stray);
    end
  endtask

  task automatic test_last_beat_pkt();
    logic [DDW-1:0] d;
    new_scoreboard();
    grant(0, 1'b0, AW'($urandom));
    xfer(0, 1'b0, 1'b0, -1, BEATS - 1);
    d = $urandom;
    set_pkt(1, $urandom_range(0, 1) == 1, AW'($urandom));
    bus.mem_dma_data_i         = d;
    bus.mem_dma_data_v_i       = 1'b1;
    bus.cache_dma_data_ready_i = onehot(0);
    bus.cache_dma_pkt_v_i      = onehot(1);
    #1;
    checks++;
    if (bus.cache_dma_data_v_o !== onehot(0) || bus.cache_dma_data_o !== d || bus.mem_dma_pkt_v_o !== 1'b0 || bus.cache_dma_pkt_yumi_o !== '0) begin
      errors++;
      $display("FAIL lastbeat_cycle: got data_v=%b data=%h pkt_v=%0b yumi=%b want %b %h 0 0",
               bus.cache_dma_data_v_o, bus.cache_dma_data_o, bus.mem_dma_pkt_v_o, bus.cache_dma_pkt_yumi_o, onehot(0), d);
    end
    tick();
    bus.mem_dma_data_v_i       = 1'b0;
    bus.cache_dma_data_ready_i = '0;
    #1;
    checks++;
    if (bus.mem_dma_pkt_v_o !== 1'b1 || bus.mem_cache_id_o !== IDW'(rr_pick(2, ptr_m)) || bus.mem_dma_pkt_o !== pkt_m[1]) begin
      errors++;
      $display("FAIL lastbeat_next: got v=%0b id=%0d pkt=%h want v=1 id=%0d pkt=%h",
               bus.mem_dma_pkt_v_o, bus.mem_cache_id_o, bus.mem_dma_pkt_o, rr_pick(2, ptr_m), pkt_m[1]);
    end
    bus.mem_dma_pkt_yumi_i = 1'b1;
    #1;
    checks++;
    if (bus.cache_dma_pkt_yumi_o !== onehot(1)) begin
      errors++; $display("FAIL lastbeat_yumi: got %b want %b", bus.cache_dma_pkt_yumi_o, onehot(1));
    end
    tick();
    bus.mem_dma_pkt_yumi_i = 1'b0;
    bus.cache_dma_pkt_v_i  = '0;
    ptr_m = 2 % N;
    new_scoreboard();
    xfer(1, pkt_m[1][AW], 1'b0, -1, BEATS);
    checks++;
    if (bad_beats() != 0 || stray != 0) begin
      errors++; $display("FAIL lastbeat_xfer: got %0d bad beats %0d stray cycles want 0 0", bad_beats(), stray);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_rr_alternate();
    test_evict();
    test_fill_stall();
    test_reset_mid_evict();
    test_last_beat_pkt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
